// File: rtl/sd_req_arbiter.sv
// Multi-channel SD sector request arbiter: latches per-channel read/write requests, hands them round-robin
// to the MCU for LBA translation, then runs one sd_rw start/sector/done handshake per request.
module sd_req_arbiter #(
    parameter int          CHANNELS = 8,
    parameter logic [23:0] TIMEOUT  = 24'd5000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNELS-1:0]      rstart,
    input  logic [CHANNELS-1:0]      wstart,
    input  logic [32*CHANNELS-1:0]   rsector,
    output logic [CHANNELS-1:0]      ch_busy,
    output logic [CHANNELS-1:0]      ch_done,
    output logic [CHANNELS-1:0]      ch_err,
    output logic [2:0]               grant,
    input  logic                     data_strobe,
    input  logic                     data_start,
    input  logic [7:0]               data_in,
    output logic [7:0]               data_out,
    output logic                     irq,
    input  logic                     iack,
    output logic                     sd_rstart,
    output logic                     sd_wstart,
    output logic [31:0]              sd_sector,
    input  logic                     sd_done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ANNOUNCE = 2'd1,
        SD_IO    = 2'd2,
        FAIL     = 2'd3
    } state_t;

    localparam logic [2:0] LAST_CH = 3'(CHANNELS - 1);

    state_t state, state_nxt;

    logic [CHANNELS-1:0] rstart_d, wstart_d, redge, wedge;
    logic [7:0]          pend, op;
    logic [31:0]         lsec [8];
    logic                svc_op;
    logic [31:0]         svc_lsec;
    logic [2:0]          rr;
    logic [23:0]         timer;
    logic [7:0]          cmd;
    logic [3:0]          byte_cnt;
    logic                pick_found;
    logic [2:0]          pick_idx;
    logic [3:0]          scan_j;
    logic [7:0]          grant_oh;
    logic [2:0]          next_rr;
    logic                cmd_stb, byte_stb;
    logic                lba_last, abort_hit, timer_exp;
    logic [7:0]          rd_byte, hdr;

    assign redge    = rstart & ~rstart_d;
    assign wedge    = wstart & ~wstart_d;
    assign grant_oh = 8'd1 << grant;
    assign next_rr  = (grant == LAST_CH) ? 3'd0 : grant + 3'd1;

    assign cmd_stb   = data_strobe & data_start;
    assign byte_stb  = data_strobe & ~data_start;
    assign lba_last  = byte_stb && (cmd == 8'd2) && (byte_cnt == 4'd3) && (state == ANNOUNCE);
    assign abort_hit = byte_stb && (cmd == 8'd6) && (byte_cnt == 4'd0) && (state == ANNOUNCE);
    assign timer_exp = (TIMEOUT != 24'd0) && (timer == TIMEOUT - 24'd1);

    assign ch_busy   = pend[CHANNELS-1:0] | ((state != IDLE) ? grant_oh[CHANNELS-1:0] : '0);
    assign sd_rstart = (state == SD_IO) & ~svc_op;
    assign sd_wstart = (state == SD_IO) & svc_op;

    assign hdr = {state == SD_IO, svc_op, state == ANNOUNCE, grant, 2'b00};

    // Round-robin scan: first pending channel at or after rr, wrapping at CHANNELS.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        scan_j     = 4'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            scan_j = {1'b0, rr} + 4'(i);
            if (scan_j >= 4'(CHANNELS)) scan_j = scan_j - 4'(CHANNELS);
            if (!pick_found && pend[scan_j[2:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_j[2:0];
            end
        end
    end

    // Request capture; a pending channel ignores further edges until granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstart_d <= '0;
            wstart_d <= '0;
            pend     <= '0;
            op       <= '0;
            for (int i = 0; i < 8; i++) lsec[i] <= '0;
        end else begin
            rstart_d <= rstart;
            wstart_d <= wstart;
            for (int i = 0; i < CHANNELS; i++) begin
                if (state == IDLE && pick_found && pick_idx == 3'(i)) begin
                    pend[i] <= 1'b0;
                end else if ((redge[i] | wedge[i]) && !pend[i]) begin
                    pend[i] <= 1'b1;
                    op[i]   <= wedge[i] & ~redge[i];
                    lsec[i] <= rsector[32*i +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (pick_found) state_nxt = ANNOUNCE;
            ANNOUNCE: begin
                if (lba_last)                    state_nxt = SD_IO;
                else if (abort_hit || timer_exp) state_nxt = FAIL;
            end
            SD_IO:    if (sd_done) state_nxt = IDLE;
            FAIL:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Service bookkeeping; the granted request is snapshotted so re-requests on it can queue safely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant    <= 3'd0;
            svc_op   <= 1'b0;
            svc_lsec <= '0;
            rr       <= 3'd0;
            timer    <= '0;
            irq      <= 1'b0;
            ch_done  <= '0;
            ch_err   <= '0;
        end else begin
            ch_done <= '0;
            ch_err  <= '0;
            if (state == IDLE && pick_found) irq <= 1'b1;
            else if (iack)                   irq <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant    <= pick_idx;
                        svc_op   <= op[pick_idx];
                        svc_lsec <= lsec[pick_idx];
                        timer    <= '0;
                    end
                end
                ANNOUNCE: begin
                    timer <= timer + 24'd1;
                    if (state_nxt == FAIL) ch_err <= grant_oh[CHANNELS-1:0];
                end
                SD_IO: begin
                    if (sd_done) begin
                        ch_done <= grant_oh[CHANNELS-1:0];
                        rr      <= next_rr;
                    end
                end
                FAIL:    rr <= next_rr;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_byte = 8'h00;
        case (cmd)
            8'd1: begin
                case (byte_cnt)
                    4'd0:    rd_byte = {5'b0, grant};
                    4'd1:    rd_byte = {7'b0, svc_op};
                    4'd2:    rd_byte = svc_lsec[31:24];
                    4'd3:    rd_byte = svc_lsec[23:16];
                    4'd4:    rd_byte = svc_lsec[15:8];
                    4'd5:    rd_byte = svc_lsec[7:0];
                    4'd6:    rd_byte = pend;
                    default: rd_byte = 8'h00;
                endcase
            end
            8'd2:    rd_byte = (byte_cnt < 4'd4) ? 8'hff : {7'b0, state != IDLE};
            default: rd_byte = 8'h00;
        endcase
    end

    // MCU byte interface; LBA bytes only land while the request is being announced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd       <= 8'h00;
            byte_cnt  <= 4'd0;
            data_out  <= 8'h00;
            sd_sector <= '0;
        end else if (cmd_stb) begin
            cmd      <= data_in;
            byte_cnt <= 4'd0;
            data_out <= hdr;
        end else if (byte_stb) begin
            data_out <= rd_byte;
            if (byte_cnt != 4'd15) byte_cnt <= byte_cnt + 4'd1;
            if (cmd == 8'd2 && state == ANNOUNCE) begin
                case (byte_cnt)
                    4'd0:    sd_sector[31:24] <= data_in;
                    4'd1:    sd_sector[23:16] <= data_in;
                    4'd2:    sd_sector[15:8]  <= data_in;
                    4'd3:    sd_sector[7:0]   <= data_in;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Randomised bench for sd_req_arbiter: acts as requesters, MCU and sd_rw, and checks against a
// transaction-level round-robin model of the pending requests.
module tb_sd_req_arbiter;

    localparam int CH = 8;
    localparam int TO = 100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH-1:0]     rstart = '0, wstart = '0;
    logic [32*CH-1:0]  rsector = '0;
    logic [CH-1:0]     ch_busy, ch_done, ch_err;
    logic [2:0]        grant;
    logic              data_strobe = 1'b0, data_start = 1'b0;
    logic [7:0]        data_in = '0;
    logic [7:0]        data_out;
    logic              irq;
    logic              iack = 1'b0;
    logic              sd_rstart, sd_wstart;
    logic [31:0]       sd_sector;
    logic              sd_done = 1'b0;

    sd_req_arbiter #(.CHANNELS(CH), .TIMEOUT(24'(TO))) dut (
        .clk(clk), .rst(rst), .rstart(rstart), .wstart(wstart), .rsector(rsector),
        .ch_busy(ch_busy), .ch_done(ch_done), .ch_err(ch_err), .grant(grant),
        .data_strobe(data_strobe), .data_start(data_start), .data_in(data_in),
        .data_out(data_out), .irq(irq), .iack(iack), .sd_rstart(sd_rstart),
        .sd_wstart(sd_wstart), .sd_sector(sd_sector), .sd_done(sd_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;
    int serves  = 0;
    bit allow_mid = 1'b0;

    // Model: which channels wait, what they asked for, and where the round-robin pointer sits.
    bit          m_pend [CH];
    bit          m_op   [CH];
    logic [31:0] m_sec  [CH];
    int          m_rr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_pick();
        for (int k = 0; k < CH; k++) begin
            if (m_pend[(m_rr + k) % CH]) return (m_rr + k) % CH;
        end
        return -1;
    endfunction

    function automatic logic [7:0] m_mask();
        logic [7:0] m = '0;
        for (int k = 0; k < CH; k++) m[k] = m_pend[k];
        return m;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < CH; k++) m_pend[k] = 1'b0;
        m_rr = 0;
    endtask

    task automatic req(input logic [7:0] rm, input logic [7:0] wm, input bit rnd, input logic [31:0] sec);
        logic [31:0] s;
        @(negedge clk);
        for (int i = 0; i < CH; i++) begin
            s = rnd ? 32'($urandom) : sec;
            rsector[32*i +: 32] = s;
            if ((rm[i] | wm[i]) && !m_pend[i]) begin
                m_pend[i] = 1'b1;
                m_op[i]   = wm[i] & ~rm[i];
                m_sec[i]  = s;
            end
        end
        rstart = rm[CH-1:0];
        wstart = wm[CH-1:0];
        @(negedge clk);
        rstart = '0;
        wstart = '0;
    endtask

    task automatic mcu(input bit is_cmd, input logic [7:0] b, output logic [7:0] d);
        @(negedge clk);
        data_strobe = 1'b1;
        data_start  = is_cmd;
        data_in     = b;
        @(negedge clk);
        data_strobe = 1'b0;
        data_start  = 1'b0;
        d = data_out;
    endtask

    // act: 0 translate, 1 abort, 2 timeout, 3 reset during SD_IO, 4 translate with abort sent in SD_IO
    task automatic serve(input int act, input bit wait_irq, input bit fix_lba, input logic [31:0] lba_in);
        int w, e, n;
        logic [7:0] d, mask;
        logic [31:0] lba;
        bit op_b, seen, sdio_abort;
        w = m_pick();
        if (w < 0) return;
        serves++;
        op_b = m_op[w];
        m_pend[w] = 1'b0;
        mask = m_mask();
        e = cyc;
        if (wait_irq) begin
            n = 0;
            while (irq !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("irq_set", irq, 1);
            e = cyc;
            @(negedge clk); iack = 1'b1;
            @(negedge clk); iack = 1'b0;
            chk("irq_ack", irq, 0);
        end
        chk("grant", grant, w);
        chk("busy_svc", ch_busy[w], 1);
        mcu(1, 8'd1, d); chk("st_hdr", d, {1'b0, op_b, 1'b1, 3'(w), 2'b00});
        mcu(0, 8'd0, d); chk("st_ch", d, w);
        mcu(0, 8'd0, d); chk("st_op", d, op_b);
        for (int k = 0; k < 4; k++) begin
            mcu(0, 8'd0, d); chk("st_sec", d, 8'(m_sec[w] >> (24 - 8*k)));
        end
        mcu(0, 8'd0, d); chk("st_mask", d, mask);
        if (allow_mid && $urandom_range(0, 3) == 0)
            req(8'($urandom), 8'($urandom), 1'b1, 32'd0);

        if (act == 1) begin
            mcu(1, 8'd6, d);
            mcu(0, 8'($urandom), d);
            chk("abort_err", ch_err, 64'd1 << w);
            chk("abort_nosd", sd_rstart | sd_wstart, 0);
            @(negedge clk); chk("err_pulse", ch_err, 0);
            m_rr = (w + 1) % CH;
        end else if (act == 2) begin
            seen = 1'b0;
            n = 0;
            while (ch_err == '0 && n < 200) begin
                @(negedge clk);
                n++;
                if (sd_rstart | sd_wstart) seen = 1'b1;
            end
            chk("to_err", ch_err, 64'd1 << w);
            chk("to_time", cyc - e, TO);
            chk("to_nosd", seen, 0);
            @(negedge clk); chk("err_pulse", ch_err, 0);
            m_rr = (w + 1) % CH;
        end else begin
            @(negedge clk); sd_done = 1'b1;
            @(negedge clk); sd_done = 1'b0;
            chk("stray_done", ch_done, 0);
            lba = fix_lba ? lba_in : 32'($urandom);
            mcu(1, 8'd2, d);
            for (int k = 0; k < 4; k++) begin
                mcu(0, 8'(lba >> (24 - 8*k)), d); chk("lba_ack", d, 8'hff);
            end
            chk("sd_r", sd_rstart, !op_b);
            chk("sd_w", sd_wstart, op_b);
            chk("sd_sec", sd_sector, lba);
            mcu(0, 8'd0, d); chk("lba_tail", d, 1);
            if (act == 3) begin
                rst = 1'b1;
                #1;
                chk("rst_out", {sd_rstart, sd_wstart, irq, ch_busy, ch_done, ch_err, grant, data_out}, 0);
                chk("rst_sec", sd_sector, 0);
                @(negedge clk);
                rst = 1'b0;
                m_reset();
                return;
            end
            sdio_abort = (act == 4) || ($urandom_range(0, 1) == 1);
            if (sdio_abort) begin
                mcu(1, 8'd6, d);
                mcu(0, 8'd0, d);
                chk("sdio_abort_err", ch_err, 0);
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            chk("sd_held", {sd_rstart, sd_wstart}, {!op_b, op_b});
            sd_done = 1'b1;
            @(negedge clk); sd_done = 1'b0;
            chk("done", ch_done, 64'd1 << w);
            chk("sd_off", sd_rstart | sd_wstart, 0);
            chk("busy_clr", ch_busy[w], m_pend[w]);
            m_rr = (w + 1) % CH;
            if (m_pick() < 0) begin
                @(negedge clk); chk("done_pulse", ch_done, 0);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time budget exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, rm, wm;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_state", {sd_rstart, sd_wstart, irq, ch_busy, ch_done, ch_err, grant, data_out}, 0);
        chk("rst_sector", sd_sector, 0);
        rst = 1'b0;
        @(negedge clk);

        // Idle MCU traffic: unknown command and a translate that must not touch the sector.
        mcu(1, 8'h09, d); mcu(0, 8'h00, d); chk("unk_cmd", d, 0);
        mcu(1, 8'd2, d);
        for (int k = 0; k < 4; k++) begin
            mcu(0, 8'h5a, d); chk("idle_lba_ack", d, 8'hff);
        end
        mcu(0, 8'h00, d); chk("idle_tail", d, 0);
        chk("idle_sec", sd_sector, 0);

        req(8'h04, 8'h00, 1'b0, 32'h0000_1234);
        serve(0, 1'b1, 1'b1, 32'h00AB_CDEF);
        req(8'h02, 8'h00, 1'b1, 32'd0);
        serve(2, 1'b1, 1'b0, 32'd0);
        req(8'h10, 8'h10, 1'b1, 32'd0);
        serve(0, 1'b1, 1'b0, 32'd0);
        req(8'h00, 8'h20, 1'b1, 32'd0);
        serve(0, 1'b1, 1'b0, 32'd0);
        req(8'h40, 8'h00, 1'b1, 32'd0);
        serve(1, 1'b1, 1'b0, 32'd0);
        req(8'h00, 8'h08, 1'b1, 32'd0);
        serve(4, 1'b1, 1'b0, 32'd0);
        req(8'h08, 8'h01, 1'b1, 32'd0);
        serve(3, 1'b1, 1'b0, 32'd0);

        req(8'h89, 8'h00, 1'b1, 32'd0);
        while (m_pick() >= 0) serve(0, 1'b1, 1'b0, 32'd0);
        req(8'h01, 8'h00, 1'b1, 32'd0);
        serve(0, 1'b1, 1'b0, 32'd0);

        // irq set and iack in the same cycle: set wins, the next iack clears it.
        iack = 1'b1;
        req(8'h08, 8'h00, 1'b1, 32'd0);
        @(negedge clk); chk("irq_set_wins", irq, 1);
        @(negedge clk); chk("irq_clr_after", irq, 0);
        iack = 1'b0;
        serve(1, 1'b0, 1'b0, 32'd0);

        allow_mid = 1'b1;
        for (int r = 0; r < 25; r++) begin
            rm = 8'($urandom);
            wm = 8'($urandom);
            if ((rm | wm) == 8'h00) rm = 8'h01;
            req(rm, wm, 1'b1, 32'd0);
            while (m_pick() >= 0 && serves < 400) begin
                int a;
                a = $urandom_range(0, 9);
                serve((a < 6) ? 0 : ((a < 9) ? 1 : 2), 1'b1, 1'b0, 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
